// File: rtl/dot_matrix_grid_scanner.sv
// Row-scanned dot-matrix driver rendering a GRID x GRID X/O board as 3x3 glyphs with cursor blink and win flash.
// Board inputs are snapshotted once per frame; dot_row and dot_col both register on the row-advance tick edge.
module dot_matrix_grid_scanner #(
   parameter int CLK_DIV      = 12500,
   parameter int ROWS         = 10,
   parameter int COLS         = 14,
   parameter int GRID         = 3,
   parameter int ROW_PITCH    = 3,
   parameter int COL_PITCH    = 4,
   parameter int BLINK_FRAMES = 16
) (
   input  logic                            freq,
   input  logic                            rst,
   input  logic [2*GRID*GRID-1:0]          board,
   input  logic [$clog2(GRID*GRID)-1:0]    cursor,
   input  logic                            cursor_en,
   input  logic [GRID*GRID-1:0]            win_mask,
   input  logic                            blank,
   output logic [ROWS-1:0]                 dot_row,
   output logic [COLS-1:0]                 dot_col,
   output logic                            frame_start
);
   localparam int NC = GRID * GRID;
   localparam int CW = $clog2(NC);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]   r_presc;
   logic [RW-1:0]   r_row_idx;
   logic [ROWS-1:0] r_dot_row;
   logic [COLS-1:0] r_dot_col;
   logic            r_frame_start;
   logic [BW-1:0]   r_blink_cnt;
   logic            r_phase;
   logic [2*NC-1:0] r_board;
   logic [CW-1:0]   r_cursor;
   logic            r_cursor_en;
   logic [NC-1:0]   r_win;

   logic            w_tick;
   logic            w_wrap;
   logic            w_blink_wrap;
   logic            w_next_phase;
   logic [RW-1:0]   w_next_idx;
   logic [2*NC-1:0] w_src_board;
   logic [CW-1:0]   w_src_cursor;
   logic            w_src_cursor_en;
   logic [NC-1:0]   w_src_win;
   logic [COLS-1:0] w_pix;

   function automatic logic [2:0] f_glyph(input logic [1:0] code, input int gy);
      logic [2:0] g;
      g = 3'b000;
      if (code == 2'd1)
         g = (gy == 1) ? 3'b010 : 3'b101;
      else if (code == 2'd2)
         g = (gy == 1) ? 3'b101 : 3'b010;
      return g;
   endfunction

   function automatic logic [COLS-1:0] f_row(
      input logic [RW-1:0]   y,
      input logic [2*NC-1:0] brd,
      input logic [CW-1:0]   cur,
      input logic            cen,
      input logic [NC-1:0]   win,
      input logic            ph
   );
      logic [COLS-1:0] pix;
      logic [3:0]      g;
      int              r;
      int              gy;
      int              c;
      int              gx;
      pix = '0;
      r   = int'(y) / ROW_PITCH;
      gy  = int'(y) % ROW_PITCH;
      for (int x = 0; x < COLS; x++) begin
         c  = x / COL_PITCH;
         gx = x % COL_PITCH;
         g  = 4'b0000;
         for (int k = 0; k < NC; k++) begin
            if (gy < 3 && gx < 3 && r < GRID && c < GRID && k == r * GRID + c) begin
               g[2:0] = f_glyph(brd[2*k +: 2], gy);
               // win flash outranks the cursor inversion
               if (win[k] && ph)
                  g[2:0] = 3'b000;
               else if (cen && ph && cur == CW'(k))
                  g[2:0] = ~g[2:0];
            end
         end
         pix[x] = g[gx[1:0]];
      end
      return pix;
   endfunction

   assign w_tick       = (r_presc == PW'(CLK_DIV - 1));
   assign w_wrap       = (r_row_idx == RW'(ROWS - 1));
   assign w_next_idx   = w_wrap ? '0 : r_row_idx + RW'(1);
   assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_FRAMES - 1));
   assign w_next_phase = (w_wrap && w_blink_wrap) ? ~r_phase : r_phase;

   // row 0 is rendered from the snapshot being loaded on this same edge
   assign w_src_board     = w_wrap ? board     : r_board;
   assign w_src_cursor    = w_wrap ? cursor    : r_cursor;
   assign w_src_cursor_en = w_wrap ? cursor_en : r_cursor_en;
   assign w_src_win       = w_wrap ? win_mask  : r_win;
   assign w_pix = f_row(w_next_idx, w_src_board, w_src_cursor, w_src_cursor_en, w_src_win, w_next_phase);

   always_ff @(posedge freq) begin
      if (!rst) begin
         r_presc       <= '0;
         r_row_idx     <= '0;
         r_dot_row     <= ROWS'(1);
         r_dot_col     <= '0;
         r_frame_start <= 1'b0;
         r_blink_cnt   <= '0;
         r_phase       <= 1'b0;
         r_board       <= '0;
         r_cursor      <= '0;
         r_cursor_en   <= 1'b0;
         r_win         <= '0;
      end else begin
         r_frame_start <= 1'b0;
         r_presc       <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) begin
            r_row_idx <= w_next_idx;
            r_dot_row <= ROWS'(1) << w_next_idx;
            r_dot_col <= blank ? '0 : w_pix;
            if (w_wrap) begin
               r_board       <= board;
               r_cursor      <= cursor;
               r_cursor_en   <= cursor_en;
               r_win         <= win_mask;
               r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
               r_phase       <= w_next_phase;
               r_frame_start <= 1'b1;
            end
         end
      end
   end

   assign dot_row     = r_dot_row;
   assign dot_col     = r_dot_col;
   assign frame_start = r_frame_start;
endmodule

// File: tb/tb_dot_matrix_grid_scanner.sv
// Directed bench for dot_matrix_grid_scanner: expected rows queued per frame, compared at each row tick.
module tb_dot_matrix_grid_scanner;
   localparam int CLK_DIV = 4;

   logic        freq;
   logic        rst;
   logic [17:0] board;
   logic [3:0]  cursor;
   logic        cursor_en;
   logic [8:0]  win_mask;
   logic        blank;
   logic [9:0]  dot_row;
   logic [13:0] dot_col;
   logic        frame_start;

   typedef struct packed {
      logic [7:0]  frame;
      logic [7:0]  row;
      logic [9:0]  drow;
      logic [13:0] dcol;
      logic        fs;
   } exp_t;

   exp_t        q[$];
   logic [13:0] pat[10];
   logic [9:0]  last_row;
   logic [13:0] last_col;
   int          checks = 0;
   int          errors = 0;

   dot_matrix_grid_scanner #(
      .CLK_DIV(CLK_DIV), .ROWS(10), .COLS(14), .GRID(3),
      .ROW_PITCH(3), .COL_PITCH(4), .BLINK_FRAMES(2)
   ) dut (
      .freq(freq), .rst(rst), .board(board), .cursor(cursor),
      .cursor_en(cursor_en), .win_mask(win_mask), .blank(blank),
      .dot_row(dot_row), .dot_col(dot_col), .frame_start(frame_start)
   );

   initial freq = 1'b0;
   always #5 freq = ~freq;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 10; i++) pat[i] = '0;
   endtask

   task automatic push_frame(input int fr, input int first, input int last);
      exp_t e;
      for (int y = first; y <= last; y++) begin
         e.frame = 8'(fr);
         e.row   = 8'(y);
         e.drow  = 10'(1) << y;
         e.dcol  = pat[y];
         e.fs    = (y == 0);
         q.push_back(e);
      end
   endtask

   // outputs must hold for CLK_DIV-1 edges, then the next queued row appears
   task automatic run(input int n);
      exp_t e;
      for (int t = 0; t < n; t++) begin
         for (int h = 0; h < CLK_DIV - 1; h++) begin
            @(posedge freq); #1;
            chk("hold_row", dot_row, last_row);
            chk("hold_col", dot_col, last_col);
            chk("hold_fs", frame_start, 0);
         end
         @(posedge freq); #1;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL queue_underflow observed=empty expected=entry");
         end else begin
            e = q.pop_front();
            chk($sformatf("F%0d_r%0d_row", e.frame, e.row), dot_row, e.drow);
            chk($sformatf("F%0d_r%0d_col", e.frame, e.row), dot_col, e.dcol);
            chk($sformatf("F%0d_r%0d_fs", e.frame, e.row), frame_start, e.fs);
            last_row = e.drow;
            last_col = e.dcol;
         end
      end
   endtask

   initial begin
      rst = 1'b0; board = '0; cursor = '0; cursor_en = 1'b0; win_mask = '0; blank = 1'b0;
      repeat (3) @(posedge freq);
      #1;
      chk("reset_row", dot_row, 10'h001);
      chk("reset_col", dot_col, 14'h0);
      chk("reset_fs", frame_start, 0);

      // F0: board already holds an X but the cleared snapshot must show nothing
      board = 18'h00001; rst = 1'b1;
      last_row = 10'h001; last_col = '0;
      clear_pat(); push_frame(0, 1, 9); run(9);

      // F1: X in cell 0; new board mid-frame must not tear rows 5..9
      pat[0] = 14'h005; pat[1] = 14'h002; pat[2] = 14'h005;
      push_frame(1, 0, 9); run(5);
      board = 18'h01800;
      run(5);

      // F2 (phase 1, no overrides): O in cell 5, X in cell 6
      clear_pat();
      pat[3] = 14'h200; pat[4] = 14'h500; pat[5] = 14'h200;
      pat[6] = 14'h005; pat[7] = 14'h002; pat[8] = 14'h005;
      push_frame(2, 0, 9); run(1);
      board = '0; cursor = 4'd4; cursor_en = 1'b1;
      run(9);

      // F3 phase 1 cursor solid, F4/F5 phase 0 dark, F6 phase 1 again
      clear_pat(); pat[3] = 14'h070; pat[4] = 14'h070; pat[5] = 14'h070;
      push_frame(3, 0, 9); run(10);
      clear_pat();
      push_frame(4, 0, 9); run(10);
      push_frame(5, 0, 9); run(10);
      pat[3] = 14'h070; pat[4] = 14'h070; pat[5] = 14'h070;
      push_frame(6, 0, 9); run(1);
      board = 18'h10101; win_mask = 9'h111; cursor = 4'd2;
      run(9);

      // F7 phase 1: diagonal flashed off, empty cursor cell solid
      clear_pat(); pat[0] = 14'h700; pat[1] = 14'h700; pat[2] = 14'h700;
      push_frame(7, 0, 9); run(10);

      // F8/F9 phase 0: diagonal X glyphs visible
      clear_pat();
      pat[0] = 14'h005; pat[1] = 14'h002; pat[2] = 14'h005;
      pat[3] = 14'h050; pat[4] = 14'h020; pat[5] = 14'h050;
      pat[6] = 14'h500; pat[7] = 14'h200; pat[8] = 14'h500;
      push_frame(8, 0, 9); run(1);
      cursor = 4'd4; win_mask = 9'h101;
      run(9);
      push_frame(9, 0, 9); run(10);

      // F10 phase 1: cursor inverts X in cell 4 to O; blank from row 5
      clear_pat(); pat[3] = 14'h020; pat[4] = 14'h050;
      push_frame(10, 0, 9); run(5);
      blank = 1'b1;
      run(5);

      // F11 blanked scan, then reset at row 6
      clear_pat();
      push_frame(11, 0, 6); run(7);
      rst = 1'b0;
      @(posedge freq); #1;
      chk("midreset_row", dot_row, 10'h001);
      chk("midreset_col", dot_col, 14'h0);
      chk("midreset_fs", frame_start, 0);
      rst = 1'b1;
      last_row = 10'h001; last_col = '0;
      push_frame(12, 1, 1); run(1);

      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
